// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte producers.
// Latches the winner's byte, starts the transmitter, and acks or aborts on timeout.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned Bits        = 8,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                  i_Clock,
    input  logic                  i_reset,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ*Bits-1:0] i_data,
    output logic [N_REQ-1:0]      o_ack,
    output logic [N_REQ-1:0]      o_err,
    output logic                  o_busy,
    output logic                  o_Tx_Start,
    output logic [Bits-1:0]       o_Tx_Byte,
    input  logic                  i_Tx_Done
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
    localparam logic [IdxW-1:0] PtrInit = IdxW'(N_REQ - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitDone,
        StDone,
        StAbort
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [Bits-1:0]   byte_q, byte_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  err_q, err_d;
    logic              busy_q, busy_d;
    logic              start_q, start_d;

    logic              grant_valid;
    logic [IdxW-1:0]   grant_idx;
    logic [Bits-1:0]   grant_byte;
    logic [N_REQ-1:0]  win_onehot;
    int                cand;

    // Scan from the slot after the last winner, wrapping to 0.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = int'(last_q) + i;
            if (cand >= int'(N_REQ)) begin
                cand = cand - int'(N_REQ);
            end
            if (!grant_valid && i_req[IdxW'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        grant_byte = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (grant_idx == IdxW'(k)) begin
                grant_byte = i_data[k*Bits +: Bits];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    last_d  = grant_idx;
                    byte_d  = grant_byte;
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                // A done arriving on the timeout cycle still counts as success.
                if (i_Tx_Done) begin
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    state_d = StAbort;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        win_onehot = N_REQ'(1) << last_d;
        start_d    = (state_d == StStart);
        busy_d     = (state_d != StIdle);
        ack_d      = (state_d == StDone)  ? win_onehot : '0;
        err_d      = (state_d == StAbort) ? win_onehot : '0;
    end

    always_ff @(posedge i_Clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            last_q  <= PtrInit;
            cnt_q   <= '0;
            byte_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;
    assign o_Tx_Start = start_q;
    assign o_Tx_Byte  = byte_q;

endmodule
